red_pitaya_fads_sorter: RTL and testbench
=========================================

Name: red_pitaya_fads_sorter

Overview:
- Next-generation droplet sorter for the FADS path on the RedPitaya.
- Detects droplet events on one fast-ADC channel and measures each droplet's peak amplitude and width.
- At droplet exit, gates on a peak window and a width window; on a pass, emits a delayed, timed sort pulse that triggers the ASG/HV amplifier.
- Holds per-run counters and last-droplet metrics; all configuration and readback go over the system bus.

Parameters:
- DWT, 14, ADC/threshold data width (signed).
- TW, 24, width of the width/delay/pulse counters and their registers.
- CNTW, 32, width of the event counters.

Ports:
- adc_clk_i  in  1  ADC clock; the only clock.
- adc_rstn_i  in  1  Reset, synchronous, active-low.
- adc_a_i  in  DWT  Signed ADC sample, channel A.
- sort_trig  out  1  Sort pulse to the ASG trigger.
- drop_o  out  1  High while a droplet is present (state IN_DROP).
- sys_addr  in  32  Bus address; bits [19:0] decoded.
- sys_wdata  in  32  Bus write data.
- sys_sel  in  4  Byte select; ignored (full-word writes).
- sys_wen  in  1  Bus write enable.
- sys_ren  in  1  Bus read enable.
- sys_rdata  out  32  Bus read data.
- sys_err  out  1  Bus error; always 0.
- sys_ack  out  1  Bus acknowledge.

Behaviour:
- Registers (offset, reset value):
  - 0x00 det_thr (15)
  - 0x04 peak_lo (16)
  - 0x08 peak_hi (255)
  - 0x0C wid_min (1)
  - 0x10 wid_max (2^TW-1)
  - 0x14 sort_dly (0)
  - 0x18 sort_len (100)
  - 0x1C ctrl: bit0 enable (reset 0); bit1 clear-counters, write-1 self-clearing, reads 0.
  - 0x20 drop_cnt RO; 0x24 sort_cnt RO; 0x28 last_peak RO; 0x2C last_width RO; 0x30 status RO: [1:0] state, bit2 sort_trig.
- Readback: thresholds and peak sign-extended to 32 bits; others zero-extended. Unmapped reads return 0.
- Bus: sys_ack = sys_wen|sys_ren registered, so it asserts one cycle after the request for every address. Register writes take effect on the next edge. sys_err is always 0.
- FSM states: IDLE(0), IN_DROP(1), DELAY(2), PULSE(3).
- IDLE -> IN_DROP when enable && adc_a_i > det_thr (signed compare).
  - On entry: width <= 1, peak <= adc_a_i.
- IN_DROP while adc_a_i > det_thr:
  - width increments, saturating at 2^TW-1.
  - peak <= max(peak, adc_a_i), signed.
- IN_DROP exit, on the first sample with adc_a_i <= det_thr:
  - drop_cnt++, last_peak <= peak, last_width <= width.
  - pass = peak > peak_lo && peak < peak_hi && width >= wid_min && width <= wid_max.
  - Comparisons use the final peak and width; the exit sample is excluded from both.
  - pass && sort_len != 0 -> DELAY, with the delay counter loaded from sort_dly. Otherwise -> IDLE.
- DELAY: counts down; at 0 -> PULSE, with the length counter loaded from sort_len and sort_cnt++.
  - With sort_dly = 0, PULSE is entered on the edge right after the exit edge.
- PULSE: sort_trig is registered high for exactly sort_len cycles, then -> IDLE with sort_trig low.
- Timing: if the exit sample is captured at edge E, sort_trig is high on edges E+1+sort_dly through E+sort_dly+sort_len.
- Samples above det_thr during DELAY or PULSE are ignored: not counted, not measured. Detection re-arms in IDLE.
  - If the signal is still above det_thr on returning to IDLE, a new droplet starts the next cycle.
- enable = 0 in any state: next edge goes to IDLE, sort_trig = 0, and measurements in progress are discarded (no counts).
- Config registers rewritten mid-droplet are used at their new values from the next cycle.
- Counters wrap modulo 2^CNTW. If clear and an increment fall in the same cycle, clear wins (result 0).
- Reset (adc_rstn_i = 0 at an edge):
  - All registers go to the reset values above and state to IDLE.
  - sort_trig, drop_o, sys_ack, sys_err = 0; sys_rdata = 0.
  - Any pulse in progress is truncated.

Test Plan:
- Reset defaults: hold reset 2 cycles, then read 0x00..0x30. Required: 15, 16, 255, 1, 2^24-1, 0, 100, 0, then 0s. Each read acks 1 cycle after sys_ren.
- Basic sort: enable=1, sort_dly=3, sort_len=5; drive 0, then 10 samples of 100, then 0.
  - Required: drop_o high 10 cycles; last_peak=100, last_width=10.
  - sort_trig high edges E+4..E+8; drop_cnt=1, sort_cnt=1.
- Reject: peak of 300 (>= peak_hi) -> no sort_trig, drop_cnt=1, sort_cnt=0. Repeat with width 1 and wid_min=2 -> rejected.
- Retrigger lockout: sort_dly=20; a second 100-level droplet arrives during DELAY -> drop_cnt stays 1, single 100-cycle pulse. A droplet after the pulse ends is counted.
- Abort and reset: clear enable during PULSE -> sort_trig low next cycle, state IDLE. Assert reset mid-IN_DROP -> drop_cnt=0, defaults restored.
- Boundaries:
  - sort_len=0 with a passing droplet -> no pulse.
  - Negative samples with det_thr=-50: a -40 sample starts a droplet.
  - Clear-counters written while an exit occurs in the same cycle -> counts read 0.

Source files
------------

// File: rtl/red_pitaya_fads_sorter.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
// Module   : red_pitaya_fads_sorter
// Desc     : FADS droplet sorter - peak/width gating with a delayed sort pulse.
// Revision : 1.0
// ============================================================================
module red_pitaya_fads_sorter #(
    parameter int DWT  = 14,
    parameter int TW   = 24,
    parameter int CNTW = 32
) (
    input  logic                  adc_clk_i,
    input  logic                  adc_rstn_i,
    input  logic signed [DWT-1:0] adc_a_i,
    output logic                  sort_trig,
    output logic                  drop_o,
    input  logic [31:0]           sys_addr,
    input  logic [31:0]           sys_wdata,
    input  logic [3:0]            sys_sel,
    input  logic                  sys_wen,
    input  logic                  sys_ren,
    output logic [31:0]           sys_rdata,
    output logic                  sys_err,
    output logic                  sys_ack
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_IN_DROP = 2'd1,
        S_DELAY   = 2'd2,
        S_PULSE   = 2'd3
    } state_t;

    localparam logic [19:0] c_ADDR_DET_THR    = 20'h00;
    localparam logic [19:0] c_ADDR_PEAK_LO    = 20'h04;
    localparam logic [19:0] c_ADDR_PEAK_HI    = 20'h08;
    localparam logic [19:0] c_ADDR_WID_MIN    = 20'h0C;
    localparam logic [19:0] c_ADDR_WID_MAX    = 20'h10;
    localparam logic [19:0] c_ADDR_SORT_DLY   = 20'h14;
    localparam logic [19:0] c_ADDR_SORT_LEN   = 20'h18;
    localparam logic [19:0] c_ADDR_CTRL       = 20'h1C;
    localparam logic [19:0] c_ADDR_DROP_CNT   = 20'h20;
    localparam logic [19:0] c_ADDR_SORT_CNT   = 20'h24;
    localparam logic [19:0] c_ADDR_LAST_PEAK  = 20'h28;
    localparam logic [19:0] c_ADDR_LAST_WIDTH = 20'h2C;
    localparam logic [19:0] c_ADDR_STATUS     = 20'h30;

    state_t                r_state;
    state_t                w_state_next;
    logic signed [DWT-1:0] r_det_thr;
    logic signed [DWT-1:0] r_peak_lo;
    logic signed [DWT-1:0] r_peak_hi;
    logic        [TW-1:0]  r_wid_min;
    logic        [TW-1:0]  r_wid_max;
    logic        [TW-1:0]  r_sort_dly;
    logic        [TW-1:0]  r_sort_len;
    logic                  r_enable;
    logic        [CNTW-1:0] r_drop_cnt;
    logic        [CNTW-1:0] r_sort_cnt;
    logic signed [DWT-1:0] r_last_peak;
    logic        [TW-1:0]  r_last_width;
    logic signed [DWT-1:0] r_peak;
    logic        [TW-1:0]  r_width;
    logic        [TW-1:0]  r_dly_cnt;
    logic        [TW-1:0]  r_len_cnt;
    logic                  r_trig;
    logic                  r_ack;
    logic        [31:0]    r_rdata;

    logic        [19:0]    w_addr;
    logic                  w_above;
    logic                  w_pass;
    logic                  w_exit;
    logic                  w_sort_start;
    logic                  w_clear;
    logic        [31:0]    w_rdata;
    logic                  w_unused;

    assign w_addr   = sys_addr[19:0];
    assign w_above  = adc_a_i > r_det_thr;
    assign w_pass   = (r_peak > r_peak_lo) && (r_peak < r_peak_hi) &&
                      (r_width >= r_wid_min) && (r_width <= r_wid_max);
    assign w_clear  = sys_wen && (w_addr == c_ADDR_CTRL) && sys_wdata[1];
    assign w_unused = &{1'b0, sys_sel, sys_addr[31:20], sys_wdata};

    always_ff @(posedge adc_clk_i) begin
        if (!adc_rstn_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Dropping enable aborts whatever is in flight without counting it.
    always_comb begin
        w_state_next = r_state;
        w_exit       = 1'b0;
        w_sort_start = 1'b0;
        if (!r_enable) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_above) w_state_next = S_IN_DROP;
                end
                S_IN_DROP: begin
                    if (!w_above) begin
                        w_exit       = 1'b1;
                        w_state_next = (w_pass && (r_sort_len != '0)) ? S_DELAY : S_IDLE;
                    end
                end
                S_DELAY: begin
                    if (r_dly_cnt == '0) begin
                        w_sort_start = 1'b1;
                        w_state_next = S_PULSE;
                    end
                end
                S_PULSE: begin
                    if (r_len_cnt <= TW'(1)) w_state_next = S_IDLE;
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge adc_clk_i) begin
        if (!adc_rstn_i) begin
            r_det_thr    <= DWT'(15);
            r_peak_lo    <= DWT'(16);
            r_peak_hi    <= DWT'(255);
            r_wid_min    <= TW'(1);
            r_wid_max    <= '1;
            r_sort_dly   <= '0;
            r_sort_len   <= TW'(100);
            r_enable     <= 1'b0;
            r_drop_cnt   <= '0;
            r_sort_cnt   <= '0;
            r_last_peak  <= '0;
            r_last_width <= '0;
            r_peak       <= '0;
            r_width      <= '0;
            r_dly_cnt    <= '0;
            r_len_cnt    <= '0;
            r_trig       <= 1'b0;
        end else begin
            if (sys_wen) begin
                case (w_addr)
                    c_ADDR_DET_THR:  r_det_thr  <= sys_wdata[DWT-1:0];
                    c_ADDR_PEAK_LO:  r_peak_lo  <= sys_wdata[DWT-1:0];
                    c_ADDR_PEAK_HI:  r_peak_hi  <= sys_wdata[DWT-1:0];
                    c_ADDR_WID_MIN:  r_wid_min  <= sys_wdata[TW-1:0];
                    c_ADDR_WID_MAX:  r_wid_max  <= sys_wdata[TW-1:0];
                    c_ADDR_SORT_DLY: r_sort_dly <= sys_wdata[TW-1:0];
                    c_ADDR_SORT_LEN: r_sort_len <= sys_wdata[TW-1:0];
                    c_ADDR_CTRL:     r_enable   <= sys_wdata[0];
                    default: ;
                endcase
            end

            case (r_state)
                S_IDLE: begin
                    if (w_state_next == S_IN_DROP) begin
                        r_width <= TW'(1);
                        r_peak  <= adc_a_i;
                    end
                end
                S_IN_DROP: begin
                    if (r_enable && w_above) begin
                        if (r_width != '1) r_width <= r_width + TW'(1);
                        if (adc_a_i > r_peak) r_peak <= adc_a_i;
                    end
                end
                S_DELAY: begin
                    if (r_dly_cnt != '0) r_dly_cnt <= r_dly_cnt - TW'(1);
                end
                S_PULSE: begin
                    if (r_len_cnt != '0) r_len_cnt <= r_len_cnt - TW'(1);
                end
                default: ;
            endcase

            if (w_exit) begin
                r_last_peak  <= r_peak;
                r_last_width <= r_width;
                r_dly_cnt    <= r_sort_dly;
            end
            if (w_sort_start) r_len_cnt <= r_sort_len;

            // A clear landing on the same edge as an increment wins.
            if (w_clear)           r_drop_cnt <= '0;
            else if (w_exit)       r_drop_cnt <= r_drop_cnt + CNTW'(1);
            if (w_clear)           r_sort_cnt <= '0;
            else if (w_sort_start) r_sort_cnt <= r_sort_cnt + CNTW'(1);

            r_trig <= (w_state_next == S_PULSE);
        end
    end

    always_comb begin
        w_rdata = '0;
        case (w_addr)
            c_ADDR_DET_THR:    w_rdata = 32'(r_det_thr);
            c_ADDR_PEAK_LO:    w_rdata = 32'(r_peak_lo);
            c_ADDR_PEAK_HI:    w_rdata = 32'(r_peak_hi);
            c_ADDR_WID_MIN:    w_rdata = 32'(r_wid_min);
            c_ADDR_WID_MAX:    w_rdata = 32'(r_wid_max);
            c_ADDR_SORT_DLY:   w_rdata = 32'(r_sort_dly);
            c_ADDR_SORT_LEN:   w_rdata = 32'(r_sort_len);
            c_ADDR_CTRL:       w_rdata = {31'd0, r_enable};
            c_ADDR_DROP_CNT:   w_rdata = 32'(r_drop_cnt);
            c_ADDR_SORT_CNT:   w_rdata = 32'(r_sort_cnt);
            c_ADDR_LAST_PEAK:  w_rdata = 32'(r_last_peak);
            c_ADDR_LAST_WIDTH: w_rdata = 32'(r_last_width);
            c_ADDR_STATUS:     w_rdata = {29'd0, r_trig, r_state};
            default:           w_rdata = '0;
        endcase
    end

    always_ff @(posedge adc_clk_i) begin
        if (!adc_rstn_i) begin
            r_ack   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack <= sys_wen | sys_ren;
            if (sys_ren) r_rdata <= w_rdata;
        end
    end

    assign sort_trig = r_trig;
    assign drop_o    = (r_state == S_IN_DROP);
    assign sys_rdata = r_rdata;
    assign sys_ack   = r_ack;
    assign sys_err   = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_red_pitaya_fads_sorter.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
// Module   : tb_red_pitaya_fads_sorter
// Desc     : Scoreboard bench for the FADS sorter against a timeline model.
// Revision : 1.0
// ============================================================================
module tb_red_pitaya_fads_sorter;

    localparam logic [31:0] c_DET_THR = 32'h00, c_PEAK_LO = 32'h04, c_PEAK_HI = 32'h08;
    localparam logic [31:0] c_WID_MIN = 32'h0C, c_WID_MAX = 32'h10, c_SORT_DLY = 32'h14;
    localparam logic [31:0] c_SORT_LEN = 32'h18, c_CTRL = 32'h1C, c_DROP_CNT = 32'h20;
    localparam logic [31:0] c_SORT_CNT = 32'h24, c_LAST_PEAK = 32'h28, c_LAST_WIDTH = 32'h2C;
    localparam logic [31:0] c_STATUS = 32'h30;

    typedef struct {
        bit          rd;
        logic [31:0] exp;
        int          due;
        string       name;
    } txn_t;

    typedef struct {
        bit trig;
        bit drop;
        int idx;
    } wexp_t;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic signed [13:0] adc = '0;
    logic               sort_trig, drop_o;
    logic [31:0]        sys_addr = '0, sys_wdata = '0, sys_rdata;
    logic [3:0]         sys_sel = 4'hF;
    logic               sys_wen = 1'b0, sys_ren = 1'b0, sys_err, sys_ack;

    int    n_chk = 0;
    int    n_fail = 0;
    int    cyc = 0;
    txn_t  bq[$];
    wexp_t wq[$];
    int    smp[$];

    red_pitaya_fads_sorter #(.DWT(14), .TW(24), .CNTW(32)) dut (
        .adc_clk_i (clk),
        .adc_rstn_i(rstn),
        .adc_a_i   (adc),
        .sort_trig (sort_trig),
        .drop_o    (drop_o),
        .sys_addr  (sys_addr),
        .sys_wdata (sys_wdata),
        .sys_sel   (sys_sel),
        .sys_wen   (sys_wen),
        .sys_ren   (sys_ren),
        .sys_rdata (sys_rdata),
        .sys_err   (sys_err),
        .sys_ack   (sys_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endfunction

    // Bus monitor: every ack retires the oldest outstanding request.
    always begin : mon_bus
        txn_t tx;
        @(posedge clk);
        #1;
        if (sys_ack === 1'b1) begin
            if (bq.size() == 0) begin
                chk("ack_without_request", {31'd0, sys_ack}, 32'd0);
            end else begin
                tx = bq.pop_front();
                chk({tx.name, "_ack_cycle"}, cyc, tx.due);
                if (tx.rd) chk(tx.name, sys_rdata, tx.exp);
            end
            chk("sys_err", {31'd0, sys_err}, 32'd0);
        end
    end

    // Waveform monitor: one expected (sort_trig, drop_o) pair per sampled edge.
    always begin : mon_wave
        wexp_t w;
        @(posedge clk);
        #1;
        if (wq.size() > 0) begin
            w = wq.pop_front();
            chk($sformatf("sort_trig[%0d]", w.idx), {31'd0, sort_trig}, {31'd0, w.trig});
            chk($sformatf("drop_o[%0d]", w.idx), {31'd0, drop_o}, {31'd0, w.drop});
        end
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        txn_t tx;
        sys_addr = a; sys_wdata = d; sys_wen = 1'b1;
        tx.rd = 1'b0; tx.exp = '0; tx.due = cyc + 1; tx.name = "write";
        bq.push_back(tx);
        @(posedge clk); #2;
        sys_wen = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string nm);
        txn_t tx;
        sys_addr = a; sys_ren = 1'b1;
        tx.rd = 1'b1; tx.exp = exp; tx.due = cyc + 1; tx.name = nm;
        bq.push_back(tx);
        @(posedge clk); #2;
        sys_ren = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #2; end
    endtask

    task automatic push_run(input int val, input int n);
        for (int i = 0; i < n; i++) smp.push_back(val);
    endtask

    // The model walks the sample list droplet by droplet: a droplet is a run
    // of samples above threshold starting while the sorter is re-armed; a
    // passing droplet owns the pulse window and locks out detection until
    // the edge after the pulse ends.
    task automatic run_scenario(input string nm, input int thr, input int lo, input int hi,
                                input int wmin, input int wmax, input int dly, input int len);
        int n, t, s, e, pk, low, idle_from, drops, sorts, lpk, lwd;
        bit pass;
        bit et[];
        bit ed[];
        wexp_t w;
        low = thr - 20;
        push_run(low, dly + len + 6);
        n = smp.size();
        et = new[n];
        ed = new[n];
        idle_from = 0; drops = 0; sorts = 0; lpk = 0; lwd = 0; t = 0;
        while (t < n) begin
            if (t >= idle_from && smp[t] > thr) begin
                s = t; pk = smp[s]; e = s + 1;
                while (e < n && smp[e] > thr) begin
                    if (smp[e] > pk) pk = smp[e];
                    e++;
                end
                for (int i = s; i < e; i++) ed[i] = 1'b1;
                drops++; lpk = pk; lwd = e - s;
                pass = (pk > lo) && (pk < hi) && (lwd >= wmin) && (lwd <= wmax);
                if (pass && len != 0) begin
                    for (int i = e + 1 + dly; i <= e + dly + len && i < n; i++) et[i] = 1'b1;
                    sorts++;
                    idle_from = e + dly + len + 2;
                end else begin
                    idle_from = e + 1;
                end
                t = idle_from;
            end else begin
                t++;
            end
        end

        bus_write(c_CTRL, 32'd0);
        bus_write(c_DET_THR, 32'(thr));
        bus_write(c_PEAK_LO, 32'(lo));
        bus_write(c_PEAK_HI, 32'(hi));
        bus_write(c_WID_MIN, 32'(wmin));
        bus_write(c_WID_MAX, 32'(wmax));
        bus_write(c_SORT_DLY, 32'(dly));
        bus_write(c_SORT_LEN, 32'(len));
        adc = 14'(low);
        bus_write(c_CTRL, 32'd3);

        for (int i = 0; i < n; i++) begin
            adc = 14'(smp[i]);
            w.trig = et[i]; w.drop = ed[i]; w.idx = i;
            wq.push_back(w);
            @(posedge clk); #2;
        end

        bus_read(c_DET_THR, 32'(thr), {nm, "_det_thr"});
        bus_read(c_DROP_CNT, 32'(drops), {nm, "_drop_cnt"});
        bus_read(c_SORT_CNT, 32'(sorts), {nm, "_sort_cnt"});
        if (drops > 0) begin
            bus_read(c_LAST_PEAK, 32'(lpk), {nm, "_last_peak"});
            bus_read(c_LAST_WIDTH, 32'(lwd), {nm, "_last_width"});
        end
        bus_read(c_STATUS, 32'd0, {nm, "_status"});
        smp.delete();
    endtask

    task automatic random_scenario(input int k);
        int thr, lo, hi, wmin, wmax, dly, len;
        thr  = int'($urandom_range(300)) - 100;
        lo   = thr + int'($urandom_range(60));
        hi   = lo + 20 + int'($urandom_range(200));
        wmin = 1 + int'($urandom_range(3));
        wmax = wmin + int'($urandom_range(8));
        dly  = int'($urandom_range(8));
        len  = ($urandom_range(4) == 0) ? 0 : 1 + int'($urandom_range(10));
        for (int sgi = 0; sgi < 10; sgi++) begin
            push_run(thr - int'($urandom_range(40)), 1 + int'($urandom_range(12)));
            for (int j = 0; j < 1 + int'($urandom_range(10)); j++)
                smp.push_back(thr + 1 + int'($urandom_range(300)));
        end
        run_scenario($sformatf("rand%0d", k), thr, lo, hi, wmin, wmax, dly, len);
    endtask

    // Counter clear written on the exit edge (off=0) or the sort-start edge (off=1).
    task automatic clear_race(input string nm, input int off, input int len);
        bus_write(c_SORT_LEN, 32'(len));
        adc = 14'sd0;
        bus_write(c_CTRL, 32'd1);
        adc = 14'sd100;
        idle_cycles(4);
        adc = 14'sd0;
        if (off == 1) idle_cycles(1);
        bus_write(c_CTRL, 32'd3);
        idle_cycles(len + 4);
        bus_read(c_DROP_CNT, 32'd0, {nm, "_drop_cnt"});
        bus_read(c_SORT_CNT, 32'd0, {nm, "_sort_cnt"});
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] defaults [14];
        defaults = '{32'd15, 32'd16, 32'd255, 32'd1, 32'h00FF_FFFF, 32'd0, 32'd100,
                     32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};

        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_sort_trig", {31'd0, sort_trig}, 32'd0);
        chk("rst_drop_o", {31'd0, drop_o}, 32'd0);
        chk("rst_sys_ack", {31'd0, sys_ack}, 32'd0);
        chk("rst_sys_rdata", sys_rdata, 32'd0);
        #1;
        rstn = 1'b1;
        for (int i = 0; i < 14; i++)
            bus_read(32'(i * 4), defaults[i], $sformatf("reset_reg_%02h", i * 4));

        clear_race("clr_exit", 0, 0);
        clear_race("clr_sort", 1, 3);

        push_run(0, 1); push_run(100, 10); push_run(0, 2);
        run_scenario("basic", 15, 16, 255, 1, 24'hFF_FFFF, 3, 5);
        push_run(0, 1); push_run(300, 5); push_run(0, 2);
        run_scenario("rej_peak", 15, 16, 255, 1, 24'hFF_FFFF, 3, 5);
        push_run(0, 1); push_run(100, 1); push_run(0, 2);
        run_scenario("rej_width", 15, 16, 255, 2, 24'hFF_FFFF, 3, 5);
        push_run(0, 1); push_run(100, 10); push_run(0, 5); push_run(100, 10);
        push_run(0, 114); push_run(100, 10); push_run(0, 2);
        run_scenario("lockout", 15, 16, 255, 1, 24'hFF_FFFF, 20, 100);
        push_run(0, 1); push_run(100, 6); push_run(0, 2);
        run_scenario("len0", 15, 16, 255, 1, 24'hFF_FFFF, 0, 0);
        push_run(-100, 3); push_run(-40, 4); push_run(-100, 2);
        run_scenario("negative", -50, -60, 100, 1, 24'hFF_FFFF, 2, 3);
        push_run(0, 1); push_run(16, 3); push_run(0, 1); push_run(255, 3); push_run(0, 1);
        push_run(17, 2); push_run(15, 2); push_run(254, 5); push_run(0, 1);
        run_scenario("edges", 15, 16, 255, 2, 4, 0, 1);
        for (int k = 0; k < 6; k++) random_scenario(k);

        // Abort mid-pulse by clearing enable.
        bus_write(c_CTRL, 32'd0);
        bus_write(c_DET_THR, 32'd15);
        bus_write(c_PEAK_LO, 32'd16);
        bus_write(c_PEAK_HI, 32'd255);
        bus_write(c_WID_MIN, 32'd1);
        bus_write(c_WID_MAX, 32'h00FF_FFFF);
        bus_write(c_SORT_DLY, 32'd0);
        bus_write(c_SORT_LEN, 32'd50);
        adc = 14'sd0;
        bus_write(c_CTRL, 32'd1);
        adc = 14'sd100;
        idle_cycles(4);
        adc = 14'sd0;
        for (int k = 0; k < 20 && sort_trig !== 1'b1; k++) idle_cycles(1);
        chk("abort_trig_seen", {31'd0, sort_trig}, 32'd1);
        idle_cycles(3);
        chk("abort_trig_mid", {31'd0, sort_trig}, 32'd1);
        bus_write(c_CTRL, 32'd0);
        @(posedge clk); #1;
        chk("abort_trig_low", {31'd0, sort_trig}, 32'd0);
        #1;
        bus_read(c_STATUS, 32'd0, "abort_status");
        idle_cycles(2);
        chk("abort_trig_stays_low", {31'd0, sort_trig}, 32'd0);

        // Reset in the middle of a second droplet.
        bus_write(c_SORT_LEN, 32'd0);
        bus_write(c_DET_THR, 32'd40);
        bus_write(c_CTRL, 32'd3);
        adc = 14'sd100; idle_cycles(3);
        adc = 14'sd0;   idle_cycles(2);
        adc = 14'sd100; idle_cycles(3);
        chk("rst_mid_drop_o", {31'd0, drop_o}, 32'd1);
        rstn = 1'b0;
        @(posedge clk); #2;
        rstn = 1'b1;
        chk("rst_mid_drop_o_low", {31'd0, drop_o}, 32'd0);
        adc = 14'sd0;
        bus_read(c_DROP_CNT, 32'd0, "rst_mid_drop_cnt");
        bus_read(c_CTRL, 32'd0, "rst_mid_ctrl");
        bus_read(c_DET_THR, 32'd15, "rst_mid_det_thr");
        bus_read(c_SORT_LEN, 32'd100, "rst_mid_sort_len");
        bus_read(c_STATUS, 32'd0, "rst_mid_status");
        bus_read(32'h40, 32'd0, "unmapped");

        idle_cycles(4);
        chk("bus_queue_drained", 32'(bq.size()), 32'd0);
        chk("wave_queue_drained", 32'(wq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
